// File: rtl/pmem_arbiter.sv
// Arbitrates cacheline read/write requests from NUM_PORTS caches onto one physical-memory port.
// Define PMEM_ARBITER_RR_EN for round-robin arbitration; otherwise the highest-indexed requester wins.
module pmem_arbiter #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0]             req_read,
  input  logic [NUM_PORTS-1:0]             req_write,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS*LINE_WIDTH-1:0]  req_wdata,
  output logic [NUM_PORTS-1:0]             req_resp,
  output logic [LINE_WIDTH-1:0]            req_rdata,
  output logic                             pmem_read,
  output logic                             pmem_write,
  output logic [ADDR_WIDTH-1:0]            pmem_address,
  output logic [LINE_WIDTH-1:0]            pmem_wdata,
  input  logic [LINE_WIDTH-1:0]            pmem_rdata,
  input  logic                             pmem_resp
);

  // state | meaning
  // IDLE  | no transaction outstanding; arbitrate among requesters
  // BUSY  | captured transaction on pmem, waiting for pmem_resp
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  localparam int IDX_W = $clog2(NUM_PORTS);

  logic [0:0]            state;
  logic [IDX_W-1:0]      grant_q;
  logic                  write_q;
  logic [NUM_PORTS-1:0]  requesting;
  logic                  sel_found;
  logic [IDX_W-1:0]      sel_idx;
  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [LINE_WIDTH-1:0] sel_wdata;

  assign requesting = req_read | req_write;

`ifdef PMEM_ARBITER_RR_EN
  logic [IDX_W-1:0] last_grant;
  int               cand;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = (int'(last_grant) + 1 + k) % NUM_PORTS;
      if (!sel_found && requesting[cand[IDX_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= IDX_W'(NUM_PORTS - 1);
    end else if (state == S_IDLE && sel_found) begin
      last_grant <= sel_idx;
    end
  end
`else
  // Later (higher-indexed) hits overwrite earlier ones, so data beats instruction.
  always_comb begin
    sel_found = |requesting;
    sel_idx   = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (requesting[k[IDX_W-1:0]]) begin
        sel_idx = k[IDX_W-1:0];
      end
    end
  end
`endif

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (k[IDX_W-1:0] == sel_idx) begin
        sel_write = req_write[k[IDX_W-1:0]];
        sel_addr  = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[k*LINE_WIDTH +: LINE_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      grant_q      <= '0;
      write_q      <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (sel_found) begin
            state        <= S_BUSY;
            grant_q      <= sel_idx;
            write_q      <= sel_write;
            pmem_address <= sel_addr;
            pmem_wdata   <= sel_wdata;
          end
        end
        default: begin
          if (pmem_resp) begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign pmem_read  = (state == S_BUSY) && !write_q;
  assign pmem_write = (state == S_BUSY) &&  write_q;
  assign req_rdata  = pmem_rdata;

  always_comb begin
    req_resp = '0;
    if (state == S_BUSY && pmem_resp) begin
      req_resp[grant_q] = 1'b1;
    end
  end

endmodule

// File: doc/pmem_arbiter.md
PMEM_ARBITER -- requirements
Module: pmem_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 2: number of requesting caches; port 0 is instruction, port 1 is data; legal range 2..8.
REQ-002 Parameter ADDR_WIDTH, default 32: physical address width.
REQ-003 Parameter LINE_WIDTH, default 256: cacheline width in bits.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 req_read  in  NUM_PORTS  per-port line-read request; level, held until that port's req_resp.
REQ-007 req_write  in  NUM_PORTS  per-port line-write (writeback) request; level, held until that port's req_resp.
REQ-008 req_addr  in  NUM_PORTS*ADDR_WIDTH  per-port line address; port i occupies slice i.
REQ-009 req_wdata  in  NUM_PORTS*LINE_WIDTH  per-port writeback data; port i occupies slice i.
REQ-010 req_resp  out  NUM_PORTS  one-cycle completion pulse to the granted port.
REQ-011 req_rdata  out  LINE_WIDTH  read line, broadcast to all ports, equal to pmem_rdata.
REQ-012 pmem_read  out  1  read command to the cacheline adapter.
REQ-013 pmem_write  out  1  write command to the cacheline adapter.
REQ-014 pmem_address  out  ADDR_WIDTH  address of the granted transaction.
REQ-015 pmem_wdata  out  LINE_WIDTH  write line of the granted transaction.
REQ-016 pmem_rdata  in  LINE_WIDTH  read line from the adapter, valid when pmem_resp is high.
REQ-017 pmem_resp  in  1  adapter completion pulse.

Function
REQ-018 The FSM SHALL have exactly two states, IDLE and BUSY.
REQ-019 A port is requesting when req_read[i] or req_write[i] is high.
REQ-020 In IDLE with at least one port requesting, the FSM SHALL select one port, capture its index, address, wdata and kind into registers, and enter BUSY on the next edge.
REQ-021 Selection SHALL be round-robin: search upward from (last_grant+1) mod NUM_PORTS; the first requesting port wins, and last_grant is updated on each grant.
REQ-022 If req_write[i] and req_read[i] are both high, the write SHALL be serviced.
REQ-023 In BUSY, the pmem_* outputs SHALL be driven only from the captured registers; pmem_read or pmem_write (never both) SHALL be high for the whole of BUSY.
REQ-024 In IDLE, pmem_read and pmem_write SHALL be 0; pmem_address and pmem_wdata SHALL hold their last values.
REQ-025 On pmem_resp in BUSY, req_resp[grant] SHALL be 1 in the same cycle (combinational), all other bits SHALL be 0, and the next state SHALL be IDLE.
REQ-026 pmem_resp in IDLE SHALL be ignored; req_resp SHALL stay 0.
REQ-027 Request changes during BUSY SHALL NOT affect the captured transaction; a requester that drops its request still receives req_resp.
REQ-028 Minimum spacing: request seen in IDLE at cycle t -> pmem command from t+1; resp at t+k -> next grant evaluated at t+k+1 (IDLE), command at t+k+2.
REQ-029 At most one transaction SHALL be outstanding at any time.

Reset
REQ-030 rst_n low SHALL asynchronously force state to IDLE, pmem_read=0, pmem_write=0, req_resp=0, pmem_address=0, pmem_wdata=0, and last_grant=NUM_PORTS-1, so that port 0 wins first.
REQ-031 Reset asserted during BUSY SHALL abort the transaction with no req_resp; after release, arbitration restarts from port 0.

Configuration
REQ-032 With macro PMEM_ARBITER_RR_EN defined, arbitration SHALL be round-robin as in REQ-021.
REQ-033 Without PMEM_ARBITER_RR_EN, arbitration SHALL be fixed priority: the highest-indexed requesting port wins (data ahead of instruction), and last_grant SHALL NOT be implemented.

Verification
REQ-034 Reset, then req_read[0]=1, addr 0x0000_1000 -> pmem_read=1 with pmem_address=0x0000_1000 one cycle later; pmem_resp with rdata 0xAA..A -> req_resp=01 in the same cycle, req_rdata=0xAA..A.
REQ-035 Ports 0 and 1 request reads continuously (RR_EN) -> grants alternate 0,1,0,1; no port is granted twice in a row.
REQ-036 req_write[1]=1, addr 0x0000_2040, wdata 0x55..5; port 1 drops its request mid-BUSY -> pmem_write stays 1 with the same addr and data until pmem_resp; req_resp=10.
REQ-037 rst_n pulsed low during BUSY -> pmem_read drops with no edge needed, no req_resp; a fresh request from port 1 is serviced normally.
REQ-038 Without RR_EN, ports 0 and 1 request simultaneously -> port 1 serviced first; pmem_resp in IDLE -> req_resp stays 00.
